sfx_speaker_mixer: RTL and testbench
====================================

# sfx_speaker_mixer

Output stage between the background-music tone generator and the PMOD speaker pin (JB[0]). It takes the 1-bit BGM square wave and plays short fight sound effects (punch, hit, KO) from a built-in segment table. While an effect is playing, the BGM is ducked (fully replaced by the effect). The block drives the speaker with one registered 1-bit output.

## Interface
- `MS_CYCLES`, 100000: clock cycles per millisecond (100 MHz Basys 3). Benches may shrink it; it must be a multiple of 4 and ≥ 8.
- `GAP_MS`, 5: silence between segments of one effect, in ms.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `bgm_in`  in  1  BGM square wave from the music stage; treated as asynchronous.
- `bgm_en`  in  1  BGM gate (level); 0 mutes the BGM path.
- `sfx_trig`  in  2  effect request, sampled every cycle: 00 none, 01 PUNCH, 10 HIT, 11 KO.
- `volume`  in  3  output level; used only with `SFX_PWM_VOL_EN`.
- `speaker`  out  1  registered speaker drive; reset 0.
- `sfx_busy`  out  1  high in PLAY or GAP; reset 0.
- `sfx_done`  out  1  one-cycle pulse when an effect ends naturally; reset 0.

## Operation
- Q = MS_CYCLES/4. The tone half-period HP is given in units of Q.
- Segment table (HP, duration):
  - PUNCH: (1Q, 30 ms), (2Q, 30 ms).
  - HIT: (2Q, 40 ms), (4Q, 60 ms).
  - KO: (2Q, 100 ms), (4Q, 100 ms), (8Q, 200 ms).
- FSM states: IDLE, PLAY, GAP.
  - IDLE: a nonzero `sfx_trig` latches the effect id, sets segment 0 and enters PLAY.
  - PLAY: the duration counter counts `dur_ms*MS_CYCLES` cycles. On expiry:
    - If more segments remain, go to GAP.
    - If this is the last segment, go to IDLE and pulse `sfx_done`.
  - GAP: lasts `GAP_MS*MS_CYCLES` cycles, then goes to PLAY with segment+1.
- Tone generator: `tone` is cleared to 0 and the half-period counter is cleared on every PLAY entry. `tone` toggles each time the counter reaches HP cycles. In GAP, `tone` is 0.
- Pre-emption: in PLAY or GAP, a trigger code numerically greater than the current id restarts at segment 0 of the new effect. Equal or lower codes are ignored. No `sfx_done` pulse is issued for an aborted effect.
- `bgm_in` passes through a 2-flop synchroniser.
- Mix:
  - `mix = sfx_busy ? tone : (bgm_sync & bgm_en)`.
  - `speaker <= mix & pwm_gate`.
- Duration and half-period counters are 32 bits wide and do not wrap within a segment.

## Timing
- A trigger sampled at rising edge n sets `sfx_busy` at edge n+1.
- The first `speaker` high of a segment appears HP cycles after PLAY entry, plus one cycle for the output register.
- BGM path latency from `bgm_in` to `speaker`: 3 cycles (2 synchroniser flops + output register).
- PLAY and GAP lengths are exact to the cycle: duration×MS_CYCLES cycles in PLAY, GAP_MS×MS_CYCLES cycles in GAP.
- `sfx_done` is asserted in the same cycle that `sfx_busy` falls.
- If a nonzero trigger arrives in the cycle the last segment expires:
  - The new effect starts (goes straight to PLAY, segment 0).
  - `sfx_done` is still pulsed.
  - `sfx_busy` stays high.
- Reset at any time: state IDLE, all counters cleared, `speaker`, `sfx_busy` and `sfx_done` go to 0 asynchronously.

## Configuration
- `SFX_PWM_VOL_EN` defined:
  - An 8-bit free-running `pwm_cnt` (reset 0) drives the gate: `pwm_gate = (pwm_cnt[7:5] <= volume)`.
  - This gives a duty of (volume+1)/8; 7 means always on. Carrier frequency ≈ 390 kHz.
- `SFX_PWM_VOL_EN` undefined:
  - `pwm_gate = 1`.
  - `volume` is ignored.
  - No PWM counter is built.

## Test plan
- MS_CYCLES=8, `bgm_en`=1, no trigger, drive `bgm_in` with a 10-cycle-period square → `speaker` reproduces it delayed 3 cycles. Set `bgm_en`=0 → `speaker` holds 0.
- One-cycle PUNCH pulse → `sfx_busy` high for 240+40+240 = 520 cycles. Segment 0 toggles every 2 cycles; segment 1 toggles every 4 cycles. `speaker` is 0 during the 40-cycle gap. `sfx_done` pulses once at the end.
- KO requested 100 cycles into a HIT → KO restarts at segment 0 with HP=4. There is no `sfx_done` for the HIT. A later PUNCH request during the KO is ignored.
- A new PUNCH trigger in the cycle HIT's last segment expires → `sfx_done` pulses, `sfx_busy` stays 1, and PUNCH segment 0 starts with `tone` at 0.
- Assert `reset` mid-KO (GAP state) → `speaker`, `sfx_busy` and `sfx_done` are 0 immediately. After release, the BGM path resumes with 3-cycle latency.
- With `SFX_PWM_VOL_EN`, `volume`=3, BGM held at 1 → `speaker` is high for exactly 128 of every 256 cycles. `volume`=7 → `speaker` is constantly 1.

Source files
------------

// File: rtl/sfx_speaker_mixer.sv
// sfx_speaker_mixer
// Speaker output stage: plays short fight sound effects (PUNCH, HIT, KO)
// from a built-in segment table and otherwise passes the 1-bit background
// music through. While an effect plays, the music is fully ducked.
// Optional feature: define SFX_PWM_VOL_EN to gate the output with an 8-bit
// PWM carrier controlled by `volume`; without it the gate is always open.
`timescale 1ns/1ps

module sfx_speaker_mixer #(
  parameter int unsigned MS_CYCLES = 100000,
  parameter int unsigned GAP_MS    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bgm_in,
  input  logic       bgm_en,
  input  logic [1:0] sfx_trig,
  input  logic [2:0] volume,
  output logic       speaker,
  output logic       sfx_busy,
  output logic       sfx_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Tone half-periods are expressed in quarter-milliseconds.
  localparam int unsigned Q          = MS_CYCLES / 4;
  localparam logic [31:0] GAP_CYCLES = GAP_MS * MS_CYCLES;

  state_e      state_q, state_d;
  logic [1:0]  effect_q, effect_d;
  logic [1:0]  seg_q, seg_d;
  logic [31:0] durCnt_q, durCnt_d;
  logic [31:0] hpCnt_q, hpCnt_d;
  logic        tone_q, tone_d;
  logic        done_q, done_d;
  logic        bgmMeta_q, bgmSync_q;
  logic        speaker_q;

  logic [3:0]  segHpQ;
  logic [7:0]  segMs;
  logic        segLast;
  logic [31:0] hpCycles, durCycles;
  logic        durDone, gapDone, hpDone;
  logic        startNew;
  logic        mix;
  logic        pwmGate;

  // Segment table: half-period (in Q units), duration (ms) and last-segment flag for the current effect.
  always_comb begin
    segHpQ  = 4'd1;
    segMs   = 8'd30;
    segLast = 1'b1;
    case ({effect_q, seg_q})
      4'b01_00: begin segHpQ = 4'd1; segMs = 8'd30;  segLast = 1'b0; end
      4'b01_01: begin segHpQ = 4'd2; segMs = 8'd30;  segLast = 1'b1; end
      4'b10_00: begin segHpQ = 4'd2; segMs = 8'd40;  segLast = 1'b0; end
      4'b10_01: begin segHpQ = 4'd4; segMs = 8'd60;  segLast = 1'b1; end
      4'b11_00: begin segHpQ = 4'd2; segMs = 8'd100; segLast = 1'b0; end
      4'b11_01: begin segHpQ = 4'd4; segMs = 8'd100; segLast = 1'b0; end
      4'b11_10: begin segHpQ = 4'd8; segMs = 8'd200; segLast = 1'b1; end
      default:  begin segHpQ = 4'd1; segMs = 8'd30;  segLast = 1'b1; end
    endcase
  end

  assign hpCycles  = 32'(segHpQ) * Q;
  assign durCycles = 32'(segMs) * MS_CYCLES;
  assign durDone   = (durCnt_q == durCycles - 32'd1);
  assign gapDone   = (durCnt_q == GAP_CYCLES - 32'd1);
  assign hpDone    = (hpCnt_q == hpCycles - 32'd1);

  // FSM state and effect datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      effect_q <= 2'd0;
      seg_q    <= 2'd0;
      durCnt_q <= 32'd0;
      hpCnt_q  <= 32'd0;
      tone_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      effect_q <= effect_d;
      seg_q    <= seg_d;
      durCnt_q <= durCnt_d;
      hpCnt_q  <= hpCnt_d;
      tone_q   <= tone_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: segment sequencing, tone generation, pre-emption and the done pulse.
  always_comb begin
    state_d  = state_q;
    effect_d = effect_q;
    seg_d    = seg_q;
    durCnt_d = durCnt_q + 32'd1;
    hpCnt_d  = 32'd0;
    tone_d   = 1'b0;
    done_d   = 1'b0;
    startNew = 1'b0;
    case (state_q)
      IDLE: begin
        durCnt_d = 32'd0;
        if (sfx_trig != 2'b00) startNew = 1'b1;
      end
      PLAY: begin
        if (durDone && segLast) begin
          done_d   = 1'b1;
          durCnt_d = 32'd0;
          if (sfx_trig != 2'b00) startNew = 1'b1;
          else state_d = IDLE;
        end else if (sfx_trig > effect_q) begin
          startNew = 1'b1;
        end else if (durDone) begin
          state_d  = GAP;
          durCnt_d = 32'd0;
        end else begin
          hpCnt_d = hpDone ? 32'd0 : hpCnt_q + 32'd1;
          tone_d  = hpDone ? ~tone_q : tone_q;
        end
      end
      GAP: begin
        if (sfx_trig > effect_q) begin
          startNew = 1'b1;
        end else if (gapDone) begin
          state_d  = PLAY;
          seg_d    = seg_q + 2'd1;
          durCnt_d = 32'd0;
        end
      end
      default: begin
        state_d  = IDLE;
        durCnt_d = 32'd0;
      end
    endcase
    if (startNew) begin
      state_d  = PLAY;
      effect_d = sfx_trig;
      seg_d    = 2'd0;
      durCnt_d = 32'd0;
      hpCnt_d  = 32'd0;
      tone_d   = 1'b0;
    end
  end

  assign sfx_busy = (state_q != IDLE);
  assign sfx_done = done_q;
  assign speaker  = speaker_q;

  // Output mix: the effect tone fully replaces the gated music while busy.
  always_comb begin
    mix = sfx_busy ? tone_q : (bgmSync_q & bgm_en);
  end

  // Two-flop synchroniser for the asynchronous music input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bgmMeta_q <= 1'b0;
      bgmSync_q <= 1'b0;
    end else begin
      bgmMeta_q <= bgm_in;
      bgmSync_q <= bgmMeta_q;
    end
  end

  // Registered speaker drive so the pin never sees combinational glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) speaker_q <= 1'b0;
    else       speaker_q <= mix & pwmGate;
  end

`ifdef SFX_PWM_VOL_EN
  logic [7:0] pwmCnt_q;

  // Free-running PWM carrier; the top three bits set an eight-step duty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwmCnt_q <= 8'd0;
    else       pwmCnt_q <= pwmCnt_q + 8'd1;
  end

  assign pwmGate = (pwmCnt_q[7:5] <= volume);
`else
  logic unusedVolume;

  assign pwmGate      = 1'b1;
  assign unusedVolume = ^volume;
`endif

endmodule

// File: tb/tb_sfx_speaker_mixer.sv
// tb_sfx_speaker_mixer
// Self-checking bench for sfx_speaker_mixer with MS_CYCLES=8, GAP_MS=5.
// Each cycle the expected speaker/busy/done triple is pushed to a queue when
// the stimulus is driven and popped for comparison after the next clock edge.
`timescale 1ns/1ps

module tb_sfx_speaker_mixer;

  localparam int GAPC = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       bgm_in;
  logic       bgm_en;
  logic [1:0] sfx_trig;
  logic [2:0] volume;
  logic       speaker;
  logic       sfx_busy;
  logic       sfx_done;

  typedef struct packed {
    logic spk;
    logic busy;
    logic done;
  } exp_t;

  exp_t sbQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: active effect, its start cycle and the music history.
  int   curId    = 0;
  int   curStart = 0;
  int   cyc      = 0;
  logic prevBusy = 1'b0;
  logic prevTone = 1'b0;
  logic bgmH1    = 1'b0;
  logic bgmH2    = 1'b0;

  sfx_speaker_mixer #(
    .MS_CYCLES(8),
    .GAP_MS(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bgm_in(bgm_in),
    .bgm_en(bgm_en),
    .sfx_trig(sfx_trig),
    .volume(volume),
    .speaker(speaker),
    .sfx_busy(sfx_busy),
    .sfx_done(sfx_done)
  );

  // 100 MHz-style clock with a 10 ns period.
  always #5 clk = ~clk;

  // Segment half-periods in cycles (Q = 2 cycles at MS_CYCLES = 8).
  function automatic int hpOf(input int id, input int s);
    case (id)
      1: return (s == 0) ? 2 : 4;
      2: return (s == 0) ? 4 : 8;
      default: return (s == 0) ? 4 : ((s == 1) ? 8 : 16);
    endcase
  endfunction

  // Segment durations in cycles (ms * 8).
  function automatic int durOf(input int id, input int s);
    case (id)
      1: return 240;
      2: return (s == 0) ? 320 : 480;
      default: return (s == 2) ? 1600 : 800;
    endcase
  endfunction

  function automatic int segCount(input int id);
    return (id == 3) ? 3 : 2;
  endfunction

  // Expected {busy, tone, done} j cycles after an effect started, with no interruption.
  function automatic logic [2:0] fxAt(input int id, input int j);
    int t;
    t = j;
    if (id == 0 || j < 0) return 3'b000;
    for (int s = 0; s < segCount(id); s++) begin
      if (t < durOf(id, s)) return {1'b1, ((t / hpOf(id, s)) % 2) == 1, 1'b0};
      t -= durOf(id, s);
      if (s < segCount(id) - 1) begin
        if (t < GAPC) return 3'b100;
        t -= GAPC;
      end
    end
    return {2'b00, t == 0};
  endfunction

  // Drive one cycle of stimulus and push the outputs expected after the next edge.
  task automatic driveAndPush(input logic [1:0] trig, input logic bin, input logic ben);
    logic [2:0] cur;
    logic [2:0] nxt;
    exp_t       e;
    sfx_trig = trig;
    bgm_in   = bin;
    bgm_en   = ben;
    cur = fxAt(curId, cyc - curStart);
    nxt = cur;
    if (trig != 2'b00 && (cur[2] == 1'b0 || int'(trig) > curId)) begin
      curId    = int'(trig);
      curStart = cyc;
      nxt      = fxAt(curId, 0);
      nxt[0]   = cur[0];
    end
    e.spk  = prevBusy ? prevTone : (bgmH2 & ben);
    e.busy = nxt[2];
    e.done = nxt[0];
    sbQ.push_back(e);
    prevBusy = nxt[2];
    prevTone = nxt[1];
    bgmH2    = bgmH1;
    bgmH1    = bin;
    cyc++;
  endtask

  // Reset holds every output low even with a trigger and music present.
  task automatic test_reset;
    reset    = 1'b1;
    sfx_trig = 2'b11;
    bgm_in   = 1'b1;
    bgm_en   = 1'b1;
    volume   = 3'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({speaker, sfx_busy, sfx_done} !== 3'b000) begin
        failures++;
        $display("[TB] FAIL reset_hold i=%0d got spk/busy/done=%b%b%b expected=000",
                 i, speaker, sfx_busy, sfx_done);
      end
    end
    sfx_trig = 2'b00;
    bgm_in   = 1'b0;
    reset    = 1'b0;
  endtask

  // Music passes through with three register stages, then is muted by bgm_en.
  task automatic test_bgm_path;
    exp_t e;
    exp_t got;
    for (int i = 0; i < 80; i++) begin
      driveAndPush(2'b00, ((i / 5) % 2) == 1, i < 60);
      @(negedge clk);
      got = {speaker, sfx_busy, sfx_done};
      e = sbQ.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL bgm_path cyc=%0d got spk/busy/done=%b expected=%b", cyc, got, e);
      end
    end
  endtask

  // Single PUNCH: two toned segments around a silent gap, one done pulse.
  task automatic test_punch;
    exp_t e;
    exp_t got;
    int   busyCount;
    int   doneCount;
    busyCount = 0;
    doneCount = 0;
    for (int i = 0; i < 536; i++) begin
      driveAndPush((i == 5) ? 2'b01 : 2'b00, 1'b1, 1'b1);
      @(negedge clk);
      got = {speaker, sfx_busy, sfx_done};
      e = sbQ.pop_front();
      if (sfx_busy === 1'b1) busyCount++;
      if (sfx_done === 1'b1) doneCount++;
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL punch cyc=%0d got spk/busy/done=%b expected=%b", cyc, got, e);
      end
    end
    checks++;
    if (busyCount !== 520) begin
      failures++;
      $display("[TB] FAIL punch_busy_len got %0d expected 520", busyCount);
    end
    checks++;
    if (doneCount !== 1) begin
      failures++;
      $display("[TB] FAIL punch_done_count got %0d expected 1", doneCount);
    end
  endtask

  // KO pre-empts a HIT, a later PUNCH is ignored, only the KO reports done.
  task automatic test_preempt;
    exp_t       e;
    exp_t       got;
    logic [1:0] trig;
    int         doneCount;
    doneCount = 0;
    for (int i = 0; i < 3395; i++) begin
      trig = 2'b00;
      if (i == 0)   trig = 2'b10;
      if (i == 100) trig = 2'b11;
      if (i == 300) trig = 2'b01;
      driveAndPush(trig, 1'b1, 1'b1);
      @(negedge clk);
      got = {speaker, sfx_busy, sfx_done};
      e = sbQ.pop_front();
      if (sfx_done === 1'b1) doneCount++;
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL preempt cyc=%0d got spk/busy/done=%b expected=%b", cyc, got, e);
      end
    end
    checks++;
    if (doneCount !== 1) begin
      failures++;
      $display("[TB] FAIL preempt_done_count got %0d expected 1", doneCount);
    end
  endtask

  // PUNCH arrives exactly as HIT's last segment expires: done pulses, busy stays high.
  task automatic test_back_to_back;
    exp_t e;
    exp_t got;
    for (int i = 0; i < 1375; i++) begin
      driveAndPush((i == 0) ? 2'b10 : ((i == 840) ? 2'b01 : 2'b00), 1'b1, 1'b1);
      @(negedge clk);
      got = {speaker, sfx_busy, sfx_done};
      e = sbQ.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL back_to_back cyc=%0d got spk/busy/done=%b expected=%b", cyc, got, e);
      end
      if (i == 840) begin
        checks++;
        if ({sfx_busy, sfx_done} !== 2'b11) begin
          failures++;
          $display("[TB] FAIL b2b_handover got busy/done=%b%b expected=11", sfx_busy, sfx_done);
        end
      end
    end
  endtask

  // Asynchronous reset during KO's gap, then the music path recovers.
  task automatic test_reset_midko;
    exp_t e;
    exp_t got;
    for (int i = 0; i <= 810; i++) begin
      driveAndPush((i == 0) ? 2'b11 : 2'b00, 1'b1, 1'b1);
      @(negedge clk);
      got = {speaker, sfx_busy, sfx_done};
      e = sbQ.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL ko_before_reset cyc=%0d got spk/busy/done=%b expected=%b", cyc, got, e);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({speaker, sfx_busy, sfx_done} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL async_reset got spk/busy/done=%b%b%b expected=000",
               speaker, sfx_busy, sfx_done);
    end
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    curId    = 0;
    prevBusy = 1'b0;
    prevTone = 1'b0;
    bgmH1    = 1'b0;
    bgmH2    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      driveAndPush(2'b00, ((i / 5) % 2) == 1, 1'b1);
      @(negedge clk);
      got = {speaker, sfx_busy, sfx_done};
      e = sbQ.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("[TB] FAIL bgm_after_reset cyc=%0d got spk/busy/done=%b expected=%b", cyc, got, e);
      end
    end
  endtask

  // Volume gating: duty over a 256-cycle window with the music held high.
  task automatic test_pwm_volume;
    int highCount;
    int expLow;
    sfx_trig = 2'b00;
    bgm_in   = 1'b1;
    bgm_en   = 1'b1;
    volume   = 3'd3;
`ifdef SFX_PWM_VOL_EN
    expLow = 128;
`else
    expLow = 256;
`endif
    repeat (8) @(negedge clk);
    highCount = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (speaker === 1'b1) highCount++;
    end
    checks++;
    if (highCount !== expLow) begin
      failures++;
      $display("[TB] FAIL pwm_vol3 got %0d high cycles expected %0d", highCount, expLow);
    end
    volume = 3'd7;
    repeat (4) @(negedge clk);
    highCount = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (speaker === 1'b1) highCount++;
    end
    checks++;
    if (highCount !== 256) begin
      failures++;
      $display("[TB] FAIL pwm_vol7 got %0d high cycles expected 256", highCount);
    end
  endtask

  // Run every scenario in order and report one summary line.
  initial begin
    test_reset();
    test_bgm_path();
    test_punch();
    test_preempt();
    test_back_to_back();
    test_reset_midko();
    test_pwm_volume();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
